decim_capture_ctrl: RTL

DECIM_CAPTURE_CTRL -- requirements
Module: decim_capture_ctrl

---
 rtl/decim_capture_pkg.sv | 35 +++
 rtl/decim_trig_detect.sv | 56 +++++
 rtl/decim_capture_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/decim_capture_pkg.sv
// Shared types and constants for the decimated-sample capture controller.
package decim_capture_pkg;

  // Capture controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_e;

  // Trigger modes
  localparam logic [1:0] TRIG_SW   = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;
  localparam logic [1:0] TRIG_BOTH = 2'd3;

  // A capture request is usable only when it asks for at least one post sample
  // and the whole window fits in the ring buffer.
  function automatic logic cfg_valid(input logic [31:0] pretrig,
                                     input logic [31:0] post_len,
                                     input logic [31:0] depth);
    logic ok;
    if (post_len == 32'd0) begin
      ok = 1'b0;
    end else if ((pretrig + post_len) > depth) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/decim_trig_detect.sv
// Threshold-crossing detector: keeps the previous sample and flags rising,
// falling or either-edge crossings of a signed threshold.
module decim_trig_detect
  import decim_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 17
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         sample_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic signed [DATA_WIDTH-1:0] thresh_i,
  input  logic [1:0]                   mode_i,
  output logic                         edge_hit_o
);

  logic signed [DATA_WIDTH-1:0] prev_r;
  logic                         prev_valid_r;
  logic                         rise_s;
  logic                         fall_s;
  logic                         hit_s;

  // Track the last strobed sample; a clear makes it invalid so no edge can
  // be seen until a fresh sample has arrived.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_r       <= '0;
      prev_valid_r <= 1'b0;
    end else if (clear_i) begin
      prev_r       <= '0;
      prev_valid_r <= 1'b0;
    end else if (sample_i) begin
      prev_r       <= data_i;
      prev_valid_r <= 1'b1;
    end else begin
      prev_r       <= prev_r;
      prev_valid_r <= prev_valid_r;
    end
  end

  // Compare previous and current sample against the threshold per mode
  always_comb begin
    rise_s = prev_valid_r && (prev_r < thresh_i) && (data_i >= thresh_i);
    fall_s = prev_valid_r && (prev_r >= thresh_i) && (data_i < thresh_i);
    case (mode_i)
      TRIG_RISE: hit_s = rise_s;
      TRIG_FALL: hit_s = fall_s;
      TRIG_BOTH: hit_s = rise_s || fall_s;
      default:   hit_s = 1'b0;
    endcase
  end

  assign edge_hit_o = hit_s;

endmodule

// File: rtl/decim_capture_ctrl.sv
// Pre/post-trigger capture controller writing decimated samples into a
// circular capture RAM and reporting where the oldest valid sample lives.
module decim_capture_ctrl
  import decim_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         ce_i,
  input  logic                         arm_i,
  input  logic                         abort_i,
  input  logic                         sw_trig_i,
  input  logic [1:0]                   trig_mode_i,
  input  logic signed [DATA_WIDTH-1:0] thresh_i,
  input  logic [ADDR_WIDTH:0]          pretrig_i,
  input  logic [ADDR_WIDTH:0]          post_len_i,
  output logic                         we_o,
  output logic [ADDR_WIDTH-1:0]        waddr_o,
  output logic signed [DATA_WIDTH-1:0] wdata_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [ADDR_WIDTH-1:0]        start_addr_o
);

  localparam logic [31:0]           DEPTH    = 32'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1'b1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH+1)'(1'b0);

  cap_state_e                   state_r;
  logic [1:0]                   mode_r;
  logic signed [DATA_WIDTH-1:0] thresh_r;
  logic [ADDR_WIDTH:0]          pretrig_r;
  logic [ADDR_WIDTH:0]          post_len_r;
  logic [ADDR_WIDTH:0]          fill_cnt_r;
  logic [ADDR_WIDTH:0]          post_cnt_r;
  logic                         sw_pend_r;
  logic                         we_r;
  logic [ADDR_WIDTH-1:0]        waddr_r;
  logic signed [DATA_WIDTH-1:0] wdata_r;
  logic                         busy_r;
  logic                         done_r;
  logic                         err_r;
  logic [ADDR_WIDTH-1:0]        start_addr_r;

  logic                  arm_ok_s;
  logic                  idle_like_s;
  logic                  arm_go_s;
  logic                  arm_bad_s;
  logic                  sample_s;
  logic                  clear_s;
  logic                  sw_fire_s;
  logic                  edge_hit_s;
  logic                  trig_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [ADDR_WIDTH:0]   fill_next_s;
  logic [ADDR_WIDTH:0]   post_next_s;

  // Arm qualification, trigger decision and the address the next strobe lands on
  always_comb begin
    arm_ok_s    = cfg_valid(32'(pretrig_i), 32'(post_len_i), DEPTH);
    idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
    arm_go_s    = arm_i && !abort_i && idle_like_s && arm_ok_s;
    arm_bad_s   = arm_i && !abort_i && idle_like_s && !arm_ok_s;
    sample_s    = ce_i && !abort_i && ((state_r == ST_FILL) || (state_r == ST_ARMED));
    clear_s     = abort_i || arm_go_s;
    // A write issued last cycle bumps the pointer on this edge, so a sample
    // strobed now lands one slot further on.
    if (we_r) begin
      next_addr_s = waddr_r + ADDR_ONE;
    end else begin
      next_addr_s = waddr_r;
    end
    fill_next_s = fill_cnt_r + CNT_ONE;
    post_next_s = post_cnt_r + CNT_ONE;
    sw_fire_s   = (mode_r == TRIG_SW) && (sw_trig_i || sw_pend_r);
    if (ce_i && (state_r == ST_ARMED)) begin
      if (mode_r == TRIG_SW) begin
        trig_s = sw_fire_s;
      end else begin
        trig_s = edge_hit_s;
      end
    end else begin
      trig_s = 1'b0;
    end
  end

  decim_trig_detect #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_trig_detect (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_s),
    .sample_i   (sample_s),
    .data_i     (data_i),
    .thresh_i   (thresh_r),
    .mode_i     (mode_r),
    .edge_hit_o (edge_hit_s)
  );

  // Capture state machine with registered RAM write port and status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      mode_r       <= TRIG_SW;
      thresh_r     <= '0;
      pretrig_r    <= '0;
      post_len_r   <= '0;
      fill_cnt_r   <= '0;
      post_cnt_r   <= '0;
      sw_pend_r    <= 1'b0;
      we_r         <= 1'b0;
      waddr_r      <= '0;
      wdata_r      <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      start_addr_r <= '0;
    end else if (abort_i) begin
      // Abort beats everything, including an arm on the same cycle, and
      // drops the write that would otherwise appear next cycle.
      state_r   <= ST_IDLE;
      sw_pend_r <= 1'b0;
      we_r      <= 1'b0;
      waddr_r   <= next_addr_s;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      err_r   <= 1'b0;
      we_r    <= 1'b0;
      waddr_r <= next_addr_s;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (arm_go_s) begin
            mode_r       <= trig_mode_i;
            thresh_r     <= thresh_i;
            pretrig_r    <= pretrig_i;
            post_len_r   <= post_len_i;
            fill_cnt_r   <= CNT_ZERO;
            post_cnt_r   <= CNT_ZERO;
            sw_pend_r    <= 1'b0;
            waddr_r      <= '0;
            start_addr_r <= '0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            if (pretrig_i == CNT_ZERO) begin
              state_r <= ST_ARMED;
            end else begin
              state_r <= ST_FILL;
            end
          end else if (arm_bad_s) begin
            err_r <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        ST_FILL: begin
          if (sw_trig_i && (mode_r == TRIG_SW)) begin
            sw_pend_r <= 1'b1;
          end else begin
            sw_pend_r <= sw_pend_r;
          end
          if (ce_i) begin
            we_r       <= 1'b1;
            wdata_r    <= data_i;
            fill_cnt_r <= fill_next_s;
            if (fill_next_s == pretrig_r) begin
              state_r <= ST_ARMED;
            end else begin
              state_r <= ST_FILL;
            end
          end else begin
            state_r <= ST_FILL;
          end
        end
        ST_ARMED: begin
          if (ce_i) begin
            we_r    <= 1'b1;
            wdata_r <= data_i;
          end else begin
            we_r <= 1'b0;
          end
          if (trig_s) begin
            sw_pend_r    <= 1'b0;
            start_addr_r <= next_addr_s - pretrig_r[ADDR_WIDTH-1:0];
            post_cnt_r   <= CNT_ONE;
            if (post_len_r == CNT_ONE) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_POST;
            end
          end else if (sw_trig_i && (mode_r == TRIG_SW)) begin
            sw_pend_r <= 1'b1;
          end else begin
            state_r <= ST_ARMED;
          end
        end
        ST_POST: begin
          if (ce_i) begin
            we_r       <= 1'b1;
            wdata_r    <= data_i;
            post_cnt_r <= post_next_s;
            if (post_next_s == post_len_r) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_POST;
            end
          end else begin
            state_r <= ST_POST;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign we_o         = we_r;
  assign waddr_o      = waddr_r;
  assign wdata_o      = wdata_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign err_o        = err_r;
  assign start_addr_o = start_addr_r;

endmodule
